// File: rtl/stage1_pc_controller.sv
// Stage-1 PC sequencer: arbitrates sequential fetch, branch and register-jump
// updates, handshakes with instruction memory and buffers late redirects.
module stage1_pc_controller #(
    parameter int unsigned RESET_HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        inStall,
    input  logic        inBranchTaken,
    input  logic        inJumpReg,
    input  logic [15:0] inPCSourceValA,
    input  logic [15:0] inPCAddSE,
    input  logic        inMemAck,
    output logic        outFetchReq,
    output logic        conPCWrite,
    output logic        conPCSource,
    output logic        conPCAdd,
    output logic [15:0] outPCSourceValA,
    output logic [15:0] outPCAddSE,
    output logic        outValid,
    output logic        outFlush,
    output logic [1:0]  outState
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2
    } redir_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_hold_cnt;
    redir_t      r_pend;
    redir_t      w_pend_next;
    redir_t      w_req;
    redir_t      w_apply;
    logic [15:0] r_vala;
    logic [15:0] r_se;
    logic        w_active;

    // Jump beats branch when both pulse in the same cycle.
    always_comb begin
        w_req = RD_NONE;
        if (inJumpReg)
            w_req = RD_JUMP;
        else if (inBranchTaken)
            w_req = RD_BRANCH;
    end

    assign w_active = !Reset && (r_state == ST_FETCH || r_state == ST_STALLED);

    always_comb begin
        w_next_state = r_state;
        w_pend_next  = r_pend;
        w_apply      = RD_NONE;
        outFetchReq  = 1'b0;
        conPCWrite   = 1'b0;
        conPCSource  = 1'b0;
        conPCAdd     = 1'b0;
        outValid     = 1'b0;
        outFlush     = 1'b0;

        if (!Reset) begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST)
                        w_next_state = ST_FETCH;
                end
                ST_FETCH: begin
                    outFetchReq = 1'b1;
                    if (inMemAck) begin
                        if (w_req != RD_NONE)
                            w_apply = w_req;
                        else
                            w_apply = r_pend;
                        if (w_apply != RD_NONE) begin
                            w_pend_next = RD_NONE;
                        end else if (!inStall) begin
                            conPCWrite = 1'b1;
                            outValid   = 1'b1;
                        end else begin
                            w_next_state = ST_STALLED;
                        end
                    end else if (w_req != RD_NONE) begin
                        w_pend_next = w_req;
                    end
                end
                ST_STALLED: begin
                    if (w_req != RD_NONE) begin
                        w_apply      = w_req;
                        w_next_state = ST_FETCH;
                    end else if (!inStall) begin
                        conPCWrite   = 1'b1;
                        outValid     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
                default: w_next_state = ST_HOLD;
            endcase

            if (w_apply != RD_NONE) begin
                conPCWrite  = 1'b1;
                outFlush    = 1'b1;
                conPCSource = (w_apply == RD_JUMP);
                conPCAdd    = (w_apply == RD_BRANCH);
            end
        end
    end

    // A redirect seen this cycle drives its fresh operand straight through so
    // an immediate write uses it; buffered redirects use the registered copy.
    always_comb begin
        outPCSourceValA = '0;
        outPCAddSE      = '0;
        if (w_active) begin
            outPCSourceValA = (w_req == RD_JUMP)   ? inPCSourceValA : r_vala;
            outPCAddSE      = (w_req == RD_BRANCH) ? inPCAddSE      : r_se;
        end
    end

    assign outState = Reset ? 2'd0 : r_state;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_pend     <= RD_NONE;
            r_vala     <= '0;
            r_se       <= '0;
        end else begin
            r_state <= w_next_state;
            r_pend  <= w_pend_next;
            if (r_state == ST_HOLD)
                r_hold_cnt <= r_hold_cnt + 4'd1;
            if (w_active) begin
                if (w_req == RD_JUMP)
                    r_vala <= inPCSourceValA;
                else if (w_req == RD_BRANCH)
                    r_se <= inPCAddSE;
            end
        end
    end

endmodule

// File: tb/tb_stage1_pc_controller.sv
// Randomized and directed bench for stage1_pc_controller against a
// cycle-level behavioural model that also tracks the resulting PC value.
module tb_stage1_pc_controller;

    localparam int unsigned HOLD = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        inStall = 1'b0;
    logic        inBranchTaken = 1'b0;
    logic        inJumpReg = 1'b0;
    logic [15:0] inPCSourceValA = '0;
    logic [15:0] inPCAddSE = '0;
    logic        inMemAck = 1'b0;
    logic        outFetchReq, conPCWrite, conPCSource, conPCAdd;
    logic [15:0] outPCSourceValA, outPCAddSE;
    logic        outValid, outFlush;
    logic [1:0]  outState;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: phase 0=hold 1=fetch 2=stalled; pend 0=none 1=branch 2=jump
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_pend = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_se = '0;
    logic [15:0] m_pc = '0;
    logic [15:0] d_pc = '0;
    int          m_delivered = 0;
    int          d_delivered = 0;

    always #5 CLK = ~CLK;

    stage1_pc_controller #(.RESET_HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .Reset(Reset), .inStall(inStall),
        .inBranchTaken(inBranchTaken), .inJumpReg(inJumpReg),
        .inPCSourceValA(inPCSourceValA), .inPCAddSE(inPCAddSE),
        .inMemAck(inMemAck), .outFetchReq(outFetchReq),
        .conPCWrite(conPCWrite), .conPCSource(conPCSource), .conPCAdd(conPCAdd),
        .outPCSourceValA(outPCSourceValA), .outPCAddSE(outPCAddSE),
        .outValid(outValid), .outFlush(outFlush), .outState(outState)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict, check at the falling edge, advance model.
    task automatic step(input logic rst, input logic stall, input logic br, input logic jr,
                        input logic [15:0] a, input logic [15:0] se, input logic ack);
        int redir, kind, n_phase, n_pend;
        logic e_req, e_val, e_fl;
        logic [15:0] e_a, e_se;
        @(posedge CLK);
        #1;
        Reset = rst; inStall = stall; inBranchTaken = br; inJumpReg = jr;
        inPCSourceValA = a; inPCAddSE = se; inMemAck = ack;

        redir = jr ? 2 : (br ? 1 : 0);
        kind = 0;  // 0 none, 1 sequential, 2 branch, 3 jump
        e_req = 0; e_val = 0; e_fl = 0; e_a = '0; e_se = '0;
        n_phase = m_phase; n_pend = m_pend;
        if (!rst) begin
            if (m_phase != 0) begin
                e_a  = jr ? a : m_a;
                e_se = (!jr && br) ? se : m_se;
            end
            if (m_phase == 0) begin
                if (m_cnt == HOLD - 1) n_phase = 1;
            end else if (m_phase == 1) begin
                e_req = 1;
                if (ack) begin
                    int eff;
                    eff = (redir != 0) ? redir : m_pend;
                    if (eff != 0) begin
                        kind = eff + 1; n_pend = 0;
                    end else if (!stall) begin
                        kind = 1;
                    end else begin
                        n_phase = 2;
                    end
                end else if (redir != 0) begin
                    n_pend = redir;
                end
            end else begin
                if (redir != 0) begin
                    kind = redir + 1; n_phase = 1;
                end else if (!stall) begin
                    kind = 1; n_phase = 1;
                end
            end
            e_fl  = (kind >= 2);
            e_val = (kind == 1);
        end

        #4;
        chk("fetchreq", 32'(outFetchReq), 32'(e_req));
        chk("pcwrite",  32'(conPCWrite),  32'(kind != 0));
        chk("pcsource", 32'(conPCSource), 32'(kind == 3));
        chk("pcadd",    32'(conPCAdd),    32'(kind == 2));
        chk("valid",    32'(outValid),    32'(e_val));
        chk("flush",    32'(outFlush),    32'(e_fl));
        chk("state",    32'(outState),    32'(rst ? 0 : m_phase));
        chk("valA",     32'(outPCSourceValA), 32'(e_a));
        chk("addSE",    32'(outPCAddSE),  32'(e_se));

        // Architectural PC: model from its own decisions, DUT from its controls.
        if (conPCWrite)
            d_pc = conPCSource ? outPCSourceValA : d_pc + (conPCAdd ? outPCAddSE : 16'd2);
        if (outValid) d_delivered++;
        case (kind)
            1: m_pc = m_pc + 16'd2;
            2: m_pc = m_pc + e_se;
            3: m_pc = e_a;
            default: ;
        endcase
        if (kind == 1) m_delivered++;
        if (rst) begin
            m_pc = '0; d_pc = '0;
        end
        chk("pc", 32'(d_pc), 32'(m_pc));
        chk("delivered", 32'(d_delivered), 32'(m_delivered));

        if (rst) begin
            m_phase = 0; m_cnt = 0; m_pend = 0; m_a = '0; m_se = '0;
        end else begin
            if (m_phase == 0) m_cnt++;
            if (m_phase != 0) begin
                if (jr) m_a = a;
                else if (br) m_se = se;
            end
            m_phase = n_phase; m_pend = n_pend;
        end
    endtask

    initial begin
        // reset for 3 cycles, then hold, then streaming fetch with ack tied high
        repeat (3) step(1, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("reset_outputs", 32'({outFetchReq, conPCWrite, outValid, outFlush, outState}), 32'd0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("hold1_write", 32'(conPCWrite), 32'd0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("hold2_req", 32'(outFetchReq), 32'd0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("first_fetch", 32'({outFetchReq, conPCWrite, outValid}), 32'b111);
        repeat (3) step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("pc_after_4_fetches", 32'(d_pc), 32'd8);

        // decode stall for 3 cycles
        repeat (3) step(0, 1, 0, 0, 16'h0, 16'h0, 1);
        chk("stalled_state", 32'(outState), 32'd2);
        chk("stalled_nowrite", 32'(conPCWrite), 32'd0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("stall_release", 32'({conPCWrite, outValid}), 32'b11);

        // buffered branch while memory is slow
        step(0, 0, 1, 0, 16'h0, 16'hFFFC, 0);
        step(0, 0, 0, 0, 16'h5555, 16'h1111, 0);
        step(0, 0, 0, 0, 16'h5555, 16'h2222, 0);
        step(0, 0, 0, 0, 16'h5555, 16'h3333, 1);
        chk("pend_branch_ctl", 32'({conPCWrite, conPCSource, conPCAdd, outFlush}), 32'b1011);
        chk("pend_branch_se", 32'(outPCAddSE), 32'h0000FFFC);

        // simultaneous jump and branch with ack
        step(0, 0, 1, 1, 16'h1234, 16'h0008, 1);
        chk("jump_wins_src", 32'({conPCSource, conPCAdd, outFlush}), 32'b101);
        chk("jump_wins_valA", 32'(outPCSourceValA), 32'h1234);

        // redirect during STALLED
        step(0, 1, 0, 0, 16'h0, 16'h0, 1);
        step(0, 1, 0, 1, 16'h0040, 16'h0, 0);
        chk("stalled_jump", 32'({conPCWrite, conPCSource, outFlush}), 32'b111);
        step(0, 0, 0, 0, 16'h0, 16'h0, 0);
        chk("stalled_jump_next", 32'(outState), 32'd1);

        // reset while a redirect is pending
        step(0, 0, 0, 1, 16'hBEEF, 16'h0, 0);
        step(1, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("reset_midpend", 32'({outFetchReq, conPCWrite, outFlush, outState}), 32'd0);
        repeat (4) step(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("no_stale_redirect", 32'(d_pc), 32'd4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                 16'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage1_pc_controller.md
Name: stage1_pc_controller

Overview:
- Sequences the stage-1 PC incrementer. Generates the conPCWrite, conPCSource and conPCAdd controls for the PC register and its source/add muxes.
- Arbitrates the three PC-update causes: sequential fetch, PC-relative branch and register jump.
- Handshakes with instruction memory. Honours decode-stage stalls and buffers a redirect that arrives while a fetch is still in flight.
- Also drives the 16-bit operands into the incrementer (outPCSourceValA, outPCAddSE), so a buffered redirect uses the operands captured at request time.

Parameters:
- RESET_HOLD_CYCLES, 2: cycles spent in HOLD after Reset deasserts before the first fetch request (range 1..15).

Ports:
CLK  in  1  clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
inStall  in  1  decode hazard; stage 1 must not advance
inBranchTaken  in  1  one-cycle pulse; redirect to PC + inPCAddSE
inJumpReg  in  1  one-cycle pulse; redirect to inPCSourceValA
inPCSourceValA  in  16  absolute jump target
inPCAddSE  in  16  sign-extended branch offset
inMemAck  in  1  instruction memory returns a word this cycle
outFetchReq  out  1  fetch request to instruction memory
conPCWrite  out  1  PC register write enable
conPCSource  out  1  0 = adder result, 1 = outPCSourceValA
conPCAdd  out  1  0 = adder adds constant 2, 1 = adder adds outPCAddSE
outPCSourceValA  out  16  operand driven to incrementer
outPCAddSE  out  16  operand driven to incrementer
outValid  out  1  fetched word is valid for stage 2 this cycle
outFlush  out  1  squash stage-2 contents this cycle
outState  out  2  HOLD=0, FETCH=1, STALLED=2 (debug)

Behaviour:
Reset and outputs
- Reset has priority over everything, including mid-fetch and mid-stall.
- Reset forces: state HOLD; hold counter 0; pending-redirect cleared; captured operands 0x0000.
- All control outputs are Mealy (combinational from state, inputs and pending flag). Every output is 0 while Reset=1 and throughout HOLD.
- The PC register updates on the CLK edge that ends the cycle in which conPCWrite=1.

Redirect arbitration
- Simultaneous inJumpReg and inBranchTaken: the jump wins.
- Whenever a redirect request is seen in FETCH or STALLED, the block registers the relevant operand (ValA for a jump, SE for a branch) into outPCSourceValA / outPCAddSE at that edge.
- Redirect encodings:
  - Jump: conPCSource=1, conPCAdd=0.
  - Branch: conPCSource=0, conPCAdd=1.
  - Sequential: conPCSource=0, conPCAdd=0.

HOLD
- Counter increments each cycle.
- When the counter reaches RESET_HOLD_CYCLES-1, the next state is FETCH.
- Redirect and stall inputs are ignored.

FETCH
- outFetchReq=1.
- Redirect request with inMemAck=0: latch pending={type}; a later request overwrites it (jump still beats branch in the same cycle). Stay in FETCH.
- inMemAck=1 with a redirect this cycle or pending set:
  - conPCWrite=1 with the redirect encoding.
  - outFlush=1, outValid=0.
  - Clear pending; stay in FETCH.
  - Redirect applies even if inStall=1.
- inMemAck=1, no redirect, inStall=0: conPCWrite=1 sequential, outValid=1, stay in FETCH.
- inMemAck=1, no redirect, inStall=1: conPCWrite=0, outValid=0, next state STALLED.

STALLED
- outFetchReq=0. The fetched word is held by the stage-1 latch.
- Redirect request: apply immediately (conPCWrite=1, outFlush=1). Next state FETCH.
- No redirect and inStall drops to 0: conPCWrite=1 sequential, outValid=1, next state FETCH.
- Otherwise hold; no PC write.

Invariants
- At most one conPCWrite per cycle.
- outValid and outFlush are never both 1.
- conPCWrite=1 never in HOLD.

Test Plan:
- Reset held 3 cycles, release, inMemAck tied 1 -> all outputs 0 for 2 cycles (HOLD); cycle 3 outFetchReq=1, conPCWrite=1, outValid=1; PC advances by 2 per cycle.
- Ack every cycle, inStall=1 for 3 cycles at fetch N -> STALLED with conPCWrite=0 and outValid=0; on stall release one sequential write with outValid=1; no instruction lost or duplicated.
- inBranchTaken pulse with inPCAddSE=0xFFFC while inMemAck=0 for 2 more cycles -> pending latched; on ack conPCWrite=1, conPCSource=0, conPCAdd=1, outPCAddSE=0xFFFC, outFlush=1.
- inJumpReg and inBranchTaken together, ValA=0x1234, SE=0x0008, ack same cycle -> conPCSource=1, outPCSourceValA=0x1234, outFlush=1; the branch is discarded.
- Redirect during STALLED with inStall=1, ValA=0x0040 -> immediate write, conPCSource=1, outFlush=1, next state FETCH.
- Reset asserted while pending set in FETCH -> next cycle outState=0, all outputs 0, pending cleared; after release no stale redirect is applied.
